unsigned_div_seq: RTL

Sequential unsigned divider: 32-bit dividend by 16-bit divisor, giving a 16-bit quotient and a 16-bit remainder. It is the inverse-operation companion to the unsigned multiplier datapath, with the same operand widths. The multiplier's 32-bit product can be fed straight back in. It computes one quotient bit per cycle with a start/busy/done handshake. Divide-by-zero and quotient overflow are flagged, never silently wrapped.

---
 rtl/div_pkg.sv | 14 +
 rtl/unsigned_div_step.sv | 22 ++
 rtl/unsigned_div_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential unsigned divider.
package div_pkg;

  localparam int DIV_N = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [DIV_N-1:0] DIV_EXC_Q = '1;

endpackage

// File: rtl/unsigned_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module unsigned_div_step #(
  parameter int N = 16
) (
  input  logic [N:0]   r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_nxt,
  output logic [N-1:0] q_nxt
);

  // r stays below divisor, so its top bit is always 0; keeping it in the
  // trial value is numerically the same as using r[N-1:0].
  logic [N+1:0] t;
  logic         ge;

  assign t     = {r, q[N-1]};
  assign ge    = (t >= (N+2)'(divisor));
  assign r_nxt = ge ? (N+1)'(t - (N+2)'(divisor)) : t[N:0];
  assign q_nxt = {q[N-2:0], ge};

endmodule

// File: rtl/unsigned_div_seq.sv
// 2N/N unsigned restoring divider, one quotient bit per clock, with
// divide-by-zero and quotient-overflow detection.
module unsigned_div_seq
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(N) + 1;

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N:0]    r_q, r_nxt;
  logic [N-1:0]  q_q, q_nxt, dvsr_q;
  logic          exc_dz, exc_ov;
  logic          in_dz, in_ov, accept, last_step, exc, finish;

  assign in_dz     = (divisor == '0);
  assign in_ov     = !in_dz && (dividend[2*N-1:N] >= divisor);
  assign accept    = (state == IDLE) && start;
  assign last_step = (cnt == CW'(N-1));
  assign exc       = exc_dz || exc_ov;
  assign finish    = (state == RUN) && (state_nxt == DONE);

  unsigned_div_step #(.N(N)) u_step (
    .r       (r_q),
    .q       (q_q),
    .divisor (dvsr_q),
    .r_nxt   (r_nxt),
    .q_nxt   (q_nxt)
  );

  // Exceptions still spend one RUN cycle so results land on edge 1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (exc || last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      dvsr_q <= '0;
      exc_dz <= 1'b0;
      exc_ov <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      r_q    <= {1'b0, dividend[2*N-1:N]};
      q_q    <= dividend[N-1:0];
      dvsr_q <= divisor;
      exc_dz <= in_dz;
      exc_ov <= in_ov;
    end else if ((state == RUN) && !exc) begin
      cnt <= cnt + 1'b1;
      r_q <= r_nxt;
      q_q <= q_nxt;
    end
  end

  // Result registers change only on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (finish) begin
      if (exc_dz) begin
        quotient    <= '1;
        remainder   <= q_q;
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
      end else if (exc_ov) begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b0;
        overflow    <= 1'b1;
      end else begin
        quotient    <= q_nxt;
        remainder   <= r_nxt[N-1:0];
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
